// File: rtl/hazard_ctrl_pipe_if.sv
// rtl/hazard_ctrl_pipe_if.sv - ID-stage decode bundle from the opcode decoder into the hazard/control pipeline
// Signals:
//   ctrl_id   9      {Branch,ALUOp[2:0],MemWrite,MemRead,RegWrite,MemtoReg,ALUSrc}, bit8..bit0
//   id_valid  1      ID stage holds a real instruction
//   rs1_id    REG_W  source 1 index in ID
//   rs2_id    REG_W  source 2 index in ID
//   rd_id     REG_W  destination index in ID
// Modports: master = decoder (drives), slave = hazard_ctrl_pipe (receives)
interface hazard_ctrl_pipe_if #(
  parameter int REG_W = 5
);
  logic [8:0]       ctrl_id;
  logic             id_valid;
  logic [REG_W-1:0] rs1_id;
  logic [REG_W-1:0] rs2_id;
  logic [REG_W-1:0] rd_id;

  modport master (
    output ctrl_id,
    output id_valid,
    output rs1_id,
    output rs2_id,
    output rd_id
  );

  modport slave (
    input ctrl_id,
    input id_valid,
    input rs1_id,
    input rs2_id,
    input rd_id
  );
endinterface

// File: rtl/hazard_ctrl_pipe.sv
// rtl/hazard_ctrl_pipe.sv - control-word pipeline (ID/EX, EX/MEM, MEM/WB) with load-use stall, branch flush and EX forwarding selects
// Ports:
//   clk            in   1      rising-edge clock
//   reset          in   1      synchronous, active-high reset
//   id_if          slave       ID-stage control word, valid, rs1/rs2/rd
//   br_taken_ex_i  in   1      EX branch/jump resolves taken
//   pc_we_o        out  1      PC write enable
//   ifid_we_o      out  1      IF/ID register write enable
//   ifid_flush_o   out  1      zero IF/ID on next edge
//   ctrl_ex_o      out  9      control word, EX stage
//   rd_ex_o        out  REG_W  rd, EX stage
//   ctrl_mem_o     out  9      control word, MEM stage
//   rd_mem_o       out  REG_W  rd, MEM stage
//   regwrite_wb_o  out  1      RegWrite, WB stage
//   memtoreg_wb_o  out  1      MemtoReg, WB stage
//   rd_wb_o        out  REG_W  rd, WB stage
//   fwd_a_o        out  2      ALU operand A select: 00 regfile, 10 from MEM, 01 from WB
//   fwd_b_o        out  2      ALU operand B select, same encoding
//   stall_cnt_o    out  CNT_W  saturating count of load-use stall cycles
module hazard_ctrl_pipe #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  hazard_ctrl_pipe_if.slave id_if,
  input  logic              br_taken_ex_i,
  output logic              pc_we_o,
  output logic              ifid_we_o,
  output logic              ifid_flush_o,
  output logic [8:0]        ctrl_ex_o,
  output logic [REG_W-1:0]  rd_ex_o,
  output logic [8:0]        ctrl_mem_o,
  output logic [REG_W-1:0]  rd_mem_o,
  output logic              regwrite_wb_o,
  output logic              memtoreg_wb_o,
  output logic [REG_W-1:0]  rd_wb_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // Control word field positions
  localparam int B_BRANCH   = 8;
  localparam int B_MEMREAD  = 3;
  localparam int B_REGWRITE = 2;
  localparam int B_MEMTOREG = 1;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // ID/EX
  logic [8:0]       ctrl_ex_q, ctrl_ex_d;
  logic [REG_W-1:0] rd_ex_q,   rd_ex_d;
  logic [REG_W-1:0] rs1_ex_q,  rs1_ex_d;
  logic [REG_W-1:0] rs2_ex_q,  rs2_ex_d;
  // EX/MEM
  logic [8:0]       ctrl_mem_q, ctrl_mem_d;
  logic [REG_W-1:0] rd_mem_q,   rd_mem_d;
  // MEM/WB
  logic             regwrite_wb_q, regwrite_wb_d;
  logic             memtoreg_wb_q, memtoreg_wb_d;
  logic [REG_W-1:0] rd_wb_q,       rd_wb_d;
  // Stall counter
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic taken;
  logic load_use;
  logic stall;
  logic bubble;

  // MEM result is younger than WB, so it wins when both write the same register.
  function automatic logic [1:0] fwd_select(
    input logic [REG_W-1:0] rs,
    input logic             mem_we,
    input logic [REG_W-1:0] mem_rd,
    input logic             wb_we,
    input logic [REG_W-1:0] wb_rd
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_we && (mem_rd != '0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_rd != '0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    taken    = br_taken_ex_i & ctrl_ex_q[B_BRANCH];
    // A load in EX whose destination is read in ID cannot be forwarded in time.
    load_use = ctrl_ex_q[B_MEMREAD] & (rd_ex_q != '0) & id_if.id_valid &
               ((rd_ex_q == id_if.rs1_id) | (rd_ex_q == id_if.rs2_id));
    // A taken branch kills the ID instruction anyway, so it overrides the stall.
    stall    = load_use & ~taken;
    bubble   = taken | stall | ~id_if.id_valid;
  end

  always_comb begin
    pc_we_o      = ~stall;
    ifid_we_o    = ~stall;
    ifid_flush_o = taken;
  end

  always_comb begin
    ctrl_ex_d = '0;
    rd_ex_d   = '0;
    rs1_ex_d  = '0;
    rs2_ex_d  = '0;
    if (!bubble) begin
      ctrl_ex_d = id_if.ctrl_id;
      rd_ex_d   = id_if.rd_id;
      rs1_ex_d  = id_if.rs1_id;
      rs2_ex_d  = id_if.rs2_id;
    end
  end

  always_comb begin
    ctrl_mem_d    = ctrl_ex_q;
    rd_mem_d      = rd_ex_q;
    regwrite_wb_d = ctrl_mem_q[B_REGWRITE];
    memtoreg_wb_d = ctrl_mem_q[B_MEMTOREG];
    rd_wb_d       = rd_mem_q;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_ex_q     <= '0;
      rd_ex_q       <= '0;
      rs1_ex_q      <= '0;
      rs2_ex_q      <= '0;
      ctrl_mem_q    <= '0;
      rd_mem_q      <= '0;
      regwrite_wb_q <= 1'b0;
      memtoreg_wb_q <= 1'b0;
      rd_wb_q       <= '0;
      stall_cnt_q   <= '0;
    end else begin
      ctrl_ex_q     <= ctrl_ex_d;
      rd_ex_q       <= rd_ex_d;
      rs1_ex_q      <= rs1_ex_d;
      rs2_ex_q      <= rs2_ex_d;
      ctrl_mem_q    <= ctrl_mem_d;
      rd_mem_q      <= rd_mem_d;
      regwrite_wb_q <= regwrite_wb_d;
      memtoreg_wb_q <= memtoreg_wb_d;
      rd_wb_q       <= rd_wb_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  always_comb begin
    fwd_a_o = fwd_select(rs1_ex_q, ctrl_mem_q[B_REGWRITE], rd_mem_q, regwrite_wb_q, rd_wb_q);
    fwd_b_o = fwd_select(rs2_ex_q, ctrl_mem_q[B_REGWRITE], rd_mem_q, regwrite_wb_q, rd_wb_q);
  end

  assign ctrl_ex_o     = ctrl_ex_q;
  assign rd_ex_o       = rd_ex_q;
  assign ctrl_mem_o    = ctrl_mem_q;
  assign rd_mem_o      = rd_mem_q;
  assign regwrite_wb_o = regwrite_wb_q;
  assign memtoreg_wb_o = memtoreg_wb_q;
  assign rd_wb_o       = rd_wb_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// tb/tb_hazard_ctrl_pipe.sv - directed scoreboard bench for hazard_ctrl_pipe
module tb_hazard_ctrl_pipe;
  localparam int REG_W = 5;
  localparam int CNT_W = 3;

  localparam logic [8:0] C_LW  = 9'h00F;  // MemRead, RegWrite, MemtoReg, ALUSrc
  localparam logic [8:0] C_ADD = 9'h044;  // ALUOp 010, RegWrite
  localparam logic [8:0] C_SUB = 9'h064;  // ALUOp 011, RegWrite
  localparam logic [8:0] C_ADI = 9'h045;  // ALUOp 010, RegWrite, ALUSrc
  localparam logic [8:0] C_BEQ = 9'h120;  // Branch, ALUOp 001
  localparam logic [8:0] C_BLD = 9'h10C;  // Branch + MemRead + RegWrite in one word

  localparam int S_CTRL_EX = 0, S_RD_EX = 1, S_CTRL_MEM = 2, S_RD_MEM = 3;
  localparam int S_RW_WB = 4, S_M2R_WB = 5, S_RD_WB = 6, S_CNT = 7;
  localparam int S_PC_WE = 8, S_IFID_WE = 9, S_FLUSH = 10, S_FWD_A = 11, S_FWD_B = 12;

  logic clk = 1'b0;
  logic reset;
  logic br_taken_ex;
  logic pc_we, ifid_we, ifid_flush;
  logic [8:0] ctrl_ex, ctrl_mem;
  logic [REG_W-1:0] rd_ex, rd_mem, rd_wb;
  logic regwrite_wb, memtoreg_wb;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  hazard_ctrl_pipe_if #(.REG_W(REG_W)) id_if ();

  hazard_ctrl_pipe #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .id_if         (id_if),
    .br_taken_ex_i (br_taken_ex),
    .pc_we_o       (pc_we),
    .ifid_we_o     (ifid_we),
    .ifid_flush_o  (ifid_flush),
    .ctrl_ex_o     (ctrl_ex),
    .rd_ex_o       (rd_ex),
    .ctrl_mem_o    (ctrl_mem),
    .rd_mem_o      (rd_mem),
    .regwrite_wb_o (regwrite_wb),
    .memtoreg_wb_o (memtoreg_wb),
    .rd_wb_o       (rd_wb),
    .fwd_a_o       (fwd_a),
    .fwd_b_o       (fwd_b),
    .stall_cnt_o   (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          sel;
    logic [15:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int cycle = 0;
  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      S_CTRL_EX:  return 16'(ctrl_ex);
      S_RD_EX:    return 16'(rd_ex);
      S_CTRL_MEM: return 16'(ctrl_mem);
      S_RD_MEM:   return 16'(rd_mem);
      S_RW_WB:    return 16'(regwrite_wb);
      S_M2R_WB:   return 16'(memtoreg_wb);
      S_RD_WB:    return 16'(rd_wb);
      S_CNT:      return 16'(stall_cnt);
      S_PC_WE:    return 16'(pc_we);
      S_IFID_WE:  return 16'(ifid_we);
      S_FLUSH:    return 16'(ifid_flush);
      S_FWD_A:    return 16'(fwd_a);
      S_FWD_B:    return 16'(fwd_b);
      default:    return 16'hDEAD;
    endcase
  endfunction

  task automatic expect_at(input string tag, input int sel, input logic [15:0] v, input int dly);
    exp_t e;
    e.due = cycle + dly;
    e.sel = sel;
    e.exp = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    int k;
    logic [15:0] obs;
    k = 0;
    while (k < sb.size()) begin
      if (sb[k].due <= cycle) begin
        obs = observe(sb[k].sel);
        checks++;
        assert (obs === sb[k].exp) else begin
          errors++;
          $error("FAIL %s: observed %0h expected %0h", sb[k].tag, obs, sb[k].exp);
        end
        sb.delete(k);
      end else begin
        k++;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cycle++;
    drain();
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  task automatic drive(input logic v, input logic [8:0] c, input logic [REG_W-1:0] r1,
                       input logic [REG_W-1:0] r2, input logic [REG_W-1:0] rd);
    id_if.id_valid = v;
    id_if.ctrl_id  = c;
    id_if.rs1_id   = r1;
    id_if.rs2_id   = r2;
    id_if.rd_id    = rd;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 9'h000, 5'd0, 5'd0, 5'd0);
    repeat (n) cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1. reset state
    reset = 1'b1;
    br_taken_ex = 1'b0;
    drive(1'b0, 9'h000, 5'd0, 5'd0, 5'd0);
    cyc();
    cyc();
    reset = 1'b0;
    expect_at("rst_ctrl_ex", S_CTRL_EX, 16'h0, 0);
    expect_at("rst_rd_ex", S_RD_EX, 16'h0, 0);
    expect_at("rst_ctrl_mem", S_CTRL_MEM, 16'h0, 0);
    expect_at("rst_rd_mem", S_RD_MEM, 16'h0, 0);
    expect_at("rst_regwrite_wb", S_RW_WB, 16'h0, 0);
    expect_at("rst_memtoreg_wb", S_M2R_WB, 16'h0, 0);
    expect_at("rst_rd_wb", S_RD_WB, 16'h0, 0);
    expect_at("rst_stall_cnt", S_CNT, 16'h0, 0);
    expect_at("rst_pc_we", S_PC_WE, 16'h1, 0);
    expect_at("rst_ifid_we", S_IFID_WE, 16'h1, 0);
    expect_at("rst_flush", S_FLUSH, 16'h0, 0);
    expect_at("rst_fwd_a", S_FWD_A, 16'h0, 0);
    expect_at("rst_fwd_b", S_FWD_B, 16'h0, 0);
    settle();

    // 2. lw x5 then add x6,x5,x7: one stall cycle, then forward from WB
    drive(1'b1, C_LW, 5'd1, 5'd0, 5'd5);
    expect_at("lw_no_stall_pc_we", S_PC_WE, 16'h1, 0);
    settle();
    expect_at("lw_ctrl_ex", S_CTRL_EX, 16'(C_LW), 1);
    expect_at("lw_rd_ex", S_RD_EX, 16'd5, 1);
    expect_at("lw_ctrl_mem", S_CTRL_MEM, 16'(C_LW), 2);
    expect_at("lw_rd_mem", S_RD_MEM, 16'd5, 2);
    expect_at("lw_regwrite_wb", S_RW_WB, 16'h1, 3);
    expect_at("lw_memtoreg_wb", S_M2R_WB, 16'h1, 3);
    expect_at("lw_rd_wb", S_RD_WB, 16'd5, 3);
    cyc();
    drive(1'b1, C_ADD, 5'd5, 5'd7, 5'd6);
    expect_at("lu_pc_we", S_PC_WE, 16'h0, 0);
    expect_at("lu_ifid_we", S_IFID_WE, 16'h0, 0);
    expect_at("lu_flush", S_FLUSH, 16'h0, 0);
    settle();
    exp_cnt = 1;
    expect_at("lu_bubble_ctrl_ex", S_CTRL_EX, 16'h0, 1);
    expect_at("lu_stall_cnt", S_CNT, 16'(exp_cnt), 1);
    cyc();
    expect_at("lu_release_pc_we", S_PC_WE, 16'h1, 0);
    settle();
    expect_at("lu_add_ctrl_ex", S_CTRL_EX, 16'(C_ADD), 1);
    expect_at("lu_fwd_a_wb", S_FWD_A, 16'h1, 1);
    expect_at("lu_fwd_b_rf", S_FWD_B, 16'h0, 1);
    expect_at("lu_stall_cnt_hold", S_CNT, 16'(exp_cnt), 1);
    cyc();
    idle(3);

    // 3. taken branch flushes; br_taken_ex ignored for a non-branch in EX
    drive(1'b1, C_BEQ, 5'd1, 5'd2, 5'd0);
    cyc();
    drive(1'b1, C_ADI, 5'd8, 5'd0, 5'd9);
    br_taken_ex = 1'b1;
    expect_at("br_flush", S_FLUSH, 16'h1, 0);
    expect_at("br_pc_we", S_PC_WE, 16'h1, 0);
    expect_at("br_ifid_we", S_IFID_WE, 16'h1, 0);
    settle();
    expect_at("br_bubble_ctrl_ex", S_CTRL_EX, 16'h0, 1);
    expect_at("br_bubble_rd_ex", S_RD_EX, 16'h0, 1);
    cyc();
    br_taken_ex = 1'b0;
    drive(1'b1, C_ADD, 5'd1, 5'd2, 5'd3);
    cyc();
    drive(1'b1, C_ADI, 5'd8, 5'd0, 5'd9);
    br_taken_ex = 1'b1;
    expect_at("nobr_flush", S_FLUSH, 16'h0, 0);
    expect_at("nobr_pc_we", S_PC_WE, 16'h1, 0);
    settle();
    expect_at("nobr_ctrl_ex", S_CTRL_EX, 16'(C_ADI), 1);
    expect_at("nobr_rd_ex", S_RD_EX, 16'd9, 1);
    cyc();
    br_taken_ex = 1'b0;
    idle(3);

    // 4a. back-to-back add x3 ; sub x4,x3,x3 -> MEM forward, no stall
    drive(1'b1, C_ADD, 5'd1, 5'd2, 5'd3);
    cyc();
    drive(1'b1, C_SUB, 5'd3, 5'd3, 5'd4);
    expect_at("b2b_no_stall", S_PC_WE, 16'h1, 0);
    settle();
    expect_at("b2b_fwd_a", S_FWD_A, 16'h2, 1);
    expect_at("b2b_fwd_b", S_FWD_B, 16'h2, 1);
    cyc();
    idle(3);

    // 4b. add x3 ; addi x9 ; sub x4,x3,x9 -> A from WB, B from MEM
    drive(1'b1, C_ADD, 5'd1, 5'd2, 5'd3);
    cyc();
    drive(1'b1, C_ADI, 5'd8, 5'd0, 5'd9);
    cyc();
    drive(1'b1, C_SUB, 5'd3, 5'd9, 5'd4);
    expect_at("gap_fwd_a", S_FWD_A, 16'h1, 1);
    expect_at("gap_fwd_b", S_FWD_B, 16'h2, 1);
    cyc();
    idle(3);

    // 4c. destination x0 never forwards
    drive(1'b1, C_ADD, 5'd1, 5'd2, 5'd0);
    cyc();
    drive(1'b1, C_SUB, 5'd0, 5'd0, 5'd4);
    expect_at("x0_fwd_a", S_FWD_A, 16'h0, 1);
    expect_at("x0_fwd_b", S_FWD_B, 16'h0, 1);
    cyc();
    idle(3);

    // 4d. MEM and WB both write x3 -> MEM wins
    drive(1'b1, C_ADD, 5'd1, 5'd2, 5'd3);
    cyc();
    drive(1'b1, C_ADD, 5'd4, 5'd5, 5'd3);
    cyc();
    drive(1'b1, C_SUB, 5'd3, 5'd3, 5'd4);
    expect_at("prio_fwd_a", S_FWD_A, 16'h2, 1);
    expect_at("prio_fwd_b", S_FWD_B, 16'h2, 1);
    cyc();
    idle(3);

    // 5. load-use and taken branch together -> flush wins, no count
    drive(1'b1, C_BLD, 5'd1, 5'd2, 5'd5);
    cyc();
    drive(1'b1, C_ADD, 5'd5, 5'd7, 5'd6);
    br_taken_ex = 1'b1;
    expect_at("both_flush", S_FLUSH, 16'h1, 0);
    expect_at("both_pc_we", S_PC_WE, 16'h1, 0);
    expect_at("both_ifid_we", S_IFID_WE, 16'h1, 0);
    settle();
    expect_at("both_ctrl_ex", S_CTRL_EX, 16'h0, 1);
    expect_at("both_stall_cnt", S_CNT, 16'(exp_cnt), 1);
    cyc();
    br_taken_ex = 1'b0;
    idle(3);

    // load into x0 followed by a read of x0 -> no stall
    drive(1'b1, C_LW, 5'd1, 5'd0, 5'd0);
    cyc();
    drive(1'b1, C_ADD, 5'd0, 5'd0, 5'd6);
    expect_at("x0_load_no_stall", S_PC_WE, 16'h1, 0);
    settle();
    expect_at("x0_load_cnt", S_CNT, 16'(exp_cnt), 1);
    cyc();
    idle(3);

    // 6. reset with three instructions in flight
    drive(1'b1, C_LW, 5'd1, 5'd0, 5'd5);
    cyc();
    drive(1'b1, C_ADD, 5'd1, 5'd2, 5'd6);
    cyc();
    drive(1'b1, C_ADI, 5'd8, 5'd0, 5'd9);
    expect_at("fly_ctrl_ex", S_CTRL_EX, 16'(C_ADI), 1);
    expect_at("fly_ctrl_mem", S_CTRL_MEM, 16'(C_ADD), 1);
    expect_at("fly_rd_wb", S_RD_WB, 16'd5, 1);
    cyc();
    reset = 1'b1;
    exp_cnt = 0;
    expect_at("mrst_ctrl_ex", S_CTRL_EX, 16'h0, 1);
    expect_at("mrst_rd_ex", S_RD_EX, 16'h0, 1);
    expect_at("mrst_ctrl_mem", S_CTRL_MEM, 16'h0, 1);
    expect_at("mrst_rd_mem", S_RD_MEM, 16'h0, 1);
    expect_at("mrst_regwrite_wb", S_RW_WB, 16'h0, 1);
    expect_at("mrst_memtoreg_wb", S_M2R_WB, 16'h0, 1);
    expect_at("mrst_rd_wb", S_RD_WB, 16'h0, 1);
    expect_at("mrst_stall_cnt", S_CNT, 16'h0, 1);
    cyc();
    reset = 1'b0;
    idle(1);

    // saturation: self-dependent load stalls every other cycle
    drive(1'b1, C_LW, 5'd5, 5'd0, 5'd5);
    for (int i = 0; i < 10; i++) begin
      cyc();
      expect_at("sat_pc_we", S_PC_WE, 16'h0, 0);
      settle();
      if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
      expect_at("sat_stall_cnt", S_CNT, 16'(exp_cnt), 1);
      cyc();
    end
    idle(2);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
